// File: rtl/display_reg_bank_pkg.sv
// Shared constants, types and helpers for the display register bank.
// The address map lives here so the bank RTL and any software-facing model agree on it.
package display_reg_bank_pkg;

    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 4;
    localparam int NUM_WORDS   = 15;
    localparam int FRAME_CNT_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ADDR_PIPE_X  = 4'd0;
    localparam addr_t ADDR_PIPE_BT = 4'd4;
    localparam addr_t ADDR_PIPE_YS = 4'd8;
    localparam addr_t ADDR_BIRD    = 4'd12;
    localparam addr_t ADDR_SCORE   = 4'd13;
    localparam addr_t ADDR_HISCORE = 4'd14;
    localparam addr_t ADDR_CTRL    = 4'd15;

    // Unsigned maximum of three words, used when committing the high score.
    function automatic word_t max3(input word_t a, input word_t b, input word_t c);
        word_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Rising-edge detector for a slow frame-boundary level; emits a one-cycle pulse.
// After reset the level must be seen low once before any edge counts.
module frame_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;
    logic armed_q;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            level_q <= level_i;
            armed_q <= armed_q | ~level_i;
        end
    end

    // armed_q stops a level held high across reset release from looking like a new frame.
    assign pulse_o = level_i & ~level_q & armed_q;

endmodule

// File: rtl/display_reg_bank.sv
// Double-buffered display register bank: the processor fills a shadow bank and requests
// a commit; the copy to the active bank happens only on the next frame boundary.
module display_reg_bank
    import display_reg_bank_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [WORD_W-1:0]      rd_data,
    input  logic                   screen_end,
    output logic [WORD_W-1:0]      pipe1x,
    output logic [WORD_W-1:0]      pipe2x,
    output logic [WORD_W-1:0]      pipe3x,
    output logic [WORD_W-1:0]      pipe4x,
    output logic [WORD_W-1:0]      pipe1bottomtop,
    output logic [WORD_W-1:0]      pipe2bottomtop,
    output logic [WORD_W-1:0]      pipe3bottomtop,
    output logic [WORD_W-1:0]      pipe4bottomtop,
    output logic [WORD_W-1:0]      pipe1yspace,
    output logic [WORD_W-1:0]      pipe2yspace,
    output logic [WORD_W-1:0]      pipe3yspace,
    output logic [WORD_W-1:0]      pipe4yspace,
    output logic [WORD_W-1:0]      bird_top_left,
    output logic [WORD_W-1:0]      current_score,
    output logic [WORD_W-1:0]      high_score,
    output logic                   game_underway,
    output logic                   frame_tick,
    output logic                   commit_done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    word_t                  shadow_q [NUM_WORDS];
    word_t                  shadow_d [NUM_WORDS];
    word_t                  active_q [NUM_WORDS];
    word_t                  active_d [NUM_WORDS];
    logic                   pending_q, pending_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    word_t                  rd_data_q, rd_data_d;
    logic                   underway_q, underway_d;
    logic                   frame_tick_q;
    logic                   commit_done_q;
    logic                   frame_edge;
    logic                   commit;
    logic                   ctrl_wr;

    frame_edge_detect u_frame_edge (
        .clk     (clk),
        .reset   (reset),
        .level_i (screen_end),
        .pulse_o (frame_edge)
    );

    assign ctrl_wr = wr_en && (wr_addr == ADDR_CTRL);
    assign commit  = frame_edge & pending_q;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        frame_count_d = frame_count_q;
        underway_d    = 1'b0;

        if (wr_en && !ctrl_wr) begin
            shadow_d[wr_addr] = wr_data;
        end

        // Commit copies the pre-write shadow, so a same-cycle write waits for the next frame.
        if (commit) begin
            active_d               = shadow_q;
            active_d[ADDR_HISCORE] = max3(shadow_q[ADDR_HISCORE], shadow_q[ADDR_SCORE],
                                          active_q[ADDR_HISCORE]);
            pending_d              = 1'b0;
        end

        // A control write on the edge cycle re-arms the commit for the following frame.
        if (ctrl_wr) begin
            pending_d = 1'b1;
        end

        if (frame_edge) begin
            frame_count_d = frame_count_q + 1'b1;
        end

        // High score sits at the top address and is excluded from the activity flag.
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
            underway_d = underway_d | (active_q[i] != '0);
        end

        if (rd_addr == ADDR_CTRL) begin
            rd_data_d = {pending_q, {(WORD_W - 1 - FRAME_CNT_W){1'b0}}, frame_count_q};
        end else begin
            rd_data_d = active_q[rd_addr];
        end
    end

    // NOTE: both banks are reset explicitly, so this storage maps to flops rather than RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q     <= 1'b0;
            frame_count_q <= '0;
            rd_data_q     <= '0;
            underway_q    <= 1'b0;
            frame_tick_q  <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
            rd_data_q     <= rd_data_d;
            underway_q    <= underway_d;
            frame_tick_q  <= frame_edge;
            commit_done_q <= commit;
        end
    end

    assign pipe1x         = active_q[ADDR_PIPE_X];
    assign pipe2x         = active_q[ADDR_PIPE_X + 4'd1];
    assign pipe3x         = active_q[ADDR_PIPE_X + 4'd2];
    assign pipe4x         = active_q[ADDR_PIPE_X + 4'd3];
    assign pipe1bottomtop = active_q[ADDR_PIPE_BT];
    assign pipe2bottomtop = active_q[ADDR_PIPE_BT + 4'd1];
    assign pipe3bottomtop = active_q[ADDR_PIPE_BT + 4'd2];
    assign pipe4bottomtop = active_q[ADDR_PIPE_BT + 4'd3];
    assign pipe1yspace    = active_q[ADDR_PIPE_YS];
    assign pipe2yspace    = active_q[ADDR_PIPE_YS + 4'd1];
    assign pipe3yspace    = active_q[ADDR_PIPE_YS + 4'd2];
    assign pipe4yspace    = active_q[ADDR_PIPE_YS + 4'd3];
    assign bird_top_left  = active_q[ADDR_BIRD];
    assign current_score  = active_q[ADDR_SCORE];
    assign high_score     = active_q[ADDR_HISCORE];

    assign rd_data        = rd_data_q;
    assign game_underway  = underway_q;
    assign frame_tick     = frame_tick_q;
    assign commit_done    = commit_done_q;
    assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_display_reg_bank.sv
// Scoreboard bench for display_reg_bank: a behavioural model predicts every cycle's outputs,
// a negedge monitor compares them, and directed anchors pin the key scenarios to constants.
module tb_display_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr;
    logic        screen_end;

    logic [31:0] rd_data;
    logic [31:0] pipe1x, pipe2x, pipe3x, pipe4x;
    logic [31:0] pipe1bottomtop, pipe2bottomtop, pipe3bottomtop, pipe4bottomtop;
    logic [31:0] pipe1yspace, pipe2yspace, pipe3yspace, pipe4yspace;
    logic [31:0] bird_top_left, current_score, high_score;
    logic        game_underway, frame_tick, commit_done;
    logic [15:0] frame_count;

    display_reg_bank dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .screen_end     (screen_end),
        .pipe1x         (pipe1x),
        .pipe2x         (pipe2x),
        .pipe3x         (pipe3x),
        .pipe4x         (pipe4x),
        .pipe1bottomtop (pipe1bottomtop),
        .pipe2bottomtop (pipe2bottomtop),
        .pipe3bottomtop (pipe3bottomtop),
        .pipe4bottomtop (pipe4bottomtop),
        .pipe1yspace    (pipe1yspace),
        .pipe2yspace    (pipe2yspace),
        .pipe3yspace    (pipe3yspace),
        .pipe4yspace    (pipe4yspace),
        .bird_top_left  (bird_top_left),
        .current_score  (current_score),
        .high_score     (high_score),
        .game_underway  (game_underway),
        .frame_tick     (frame_tick),
        .commit_done    (commit_done),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    logic [479:0] dut_bank;
    assign dut_bank = {high_score, current_score, bird_top_left,
                       pipe4yspace, pipe3yspace, pipe2yspace, pipe1yspace,
                       pipe4bottomtop, pipe3bottomtop, pipe2bottomtop, pipe1bottomtop,
                       pipe4x, pipe3x, pipe2x, pipe1x};

    typedef struct packed {
        logic [479:0] bank;
        logic [31:0]  rd;
        logic [15:0]  cnt;
        logic         tick;
        logic         done;
        logic         gu;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: what the programmer sees, not how the RTL stores it.
    logic [31:0] m_shadow [15];
    logic [31:0] m_active [15];
    logic        m_pending;
    logic [15:0] m_count;
    logic        m_se_prev;
    logic        m_seen_low;

    task automatic check(input string name, input logic [479:0] act, input logic [479:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic model_step(output exp_t e);
        logic        edge_now;
        logic        commit_now;
        logic [31:0] best;
        e = '0;
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                m_shadow[i] = 32'd0;
                m_active[i] = 32'd0;
            end
            m_pending  = 1'b0;
            m_count    = 16'd0;
            m_se_prev  = 1'b0;
            m_seen_low = 1'b0;
        end else begin
            edge_now   = screen_end && !m_se_prev && m_seen_low;
            commit_now = edge_now && m_pending;
            e.rd   = (rd_addr == 4'd15) ? {m_pending, 15'd0, m_count} : m_active[rd_addr];
            for (int i = 0; i < 14; i++) if (m_active[i] != 32'd0) e.gu = 1'b1;
            e.tick = edge_now;
            e.done = commit_now;
            if (commit_now) begin
                best = m_active[14];
                if (m_shadow[13] > best) best = m_shadow[13];
                if (m_shadow[14] > best) best = m_shadow[14];
                for (int i = 0; i < 14; i++) m_active[i] = m_shadow[i];
                m_active[14] = best;
                m_pending = 1'b0;
            end
            if (wr_en && wr_addr != 4'd15) m_shadow[wr_addr] = wr_data;
            if (wr_en && wr_addr == 4'd15) m_pending = 1'b1;
            if (edge_now) m_count = m_count + 16'd1;
            if (!screen_end) m_seen_low = 1'b1;
            m_se_prev = screen_end;
            e.cnt = m_count;
            for (int i = 0; i < 15; i++) e.bank[i*32 +: 32] = m_active[i];
        end
    endtask

    task automatic step();
        exp_t e;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra, input bit se);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        rd_addr    = ra;
        screen_end = se;
        step();
    endtask

    task automatic hold(input bit se, input int n);
        repeat (n) drive(1'b0, 4'd0, 32'd0, 4'($urandom_range(0, 15)), se);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [31:0] wd);
        drive(1'b1, wa, wd, 4'($urandom_range(0, 15)), 1'b0);
    endtask

    task automatic frame();
        hold(1'b1, 4);
        hold(1'b0, 4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold(1'b0, 2);
        reset = 1'b0;
        hold(1'b0, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("active_bank", dut_bank, mon_e.bank);
            check("rd_data", {448'd0, rd_data}, {448'd0, mon_e.rd});
            check("frame_count", {464'd0, frame_count}, {464'd0, mon_e.cnt});
            check("frame_tick", {479'd0, frame_tick}, {479'd0, mon_e.tick});
            check("commit_done", {479'd0, commit_done}, {479'd0, mon_e.done});
            check("game_underway", {479'd0, game_underway}, {479'd0, mon_e.gu});
        end
    end

    initial begin
        int se_left;
        bit se_lvl;

        reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
        rd_addr = 4'd0; screen_end = 1'b0;
        hold(1'b0, 3);
        check("reset_bank", dut_bank, 480'd0);
        check("reset_count", {464'd0, frame_count}, 480'd0);
        reset = 1'b0;
        hold(1'b0, 1);

        // Basic commit: value stays in shadow until the frame edge.
        wr(4'd0, 32'h64);
        wr(4'd15, 32'h1);
        hold(1'b0, 1);
        check("pipe1x_before_edge", {448'd0, pipe1x}, 480'd0);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        check("pipe1x_after_edge", {448'd0, pipe1x}, 480'h64);
        check("commit_done_edge", {479'd0, commit_done}, 480'd1);
        check("frame_tick_edge", {479'd0, frame_tick}, 480'd1);
        check("underway_not_yet", {479'd0, game_underway}, 480'd0);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        check("commit_done_one_cycle", {479'd0, commit_done}, 480'd0);
        check("underway_set", {479'd0, game_underway}, 480'd1);
        hold(1'b1, 2);
        hold(1'b0, 4);

        // High score is the running maximum.
        wr(4'd14, 32'd30); wr(4'd13, 32'd0); wr(4'd15, 32'd1); frame();
        check("hiscore_30", {448'd0, high_score}, 480'd30);
        wr(4'd13, 32'd50); wr(4'd15, 32'd1); frame();
        check("hiscore_50", {448'd0, high_score}, 480'd50);
        wr(4'd13, 32'd10); wr(4'd15, 32'd1); frame();
        check("hiscore_holds_50", {448'd0, high_score}, 480'd50);
        check("score_10", {448'd0, current_score}, 480'd10);

        // Control write on the edge cycle defers the commit by one frame.
        wr(4'd1, 32'h55);
        drive(1'b1, 4'd15, 32'd0, 4'd0, 1'b1);
        check("late_ctrl_tick", {479'd0, frame_tick}, 480'd1);
        check("late_ctrl_no_commit", {479'd0, commit_done}, 480'd0);
        check("late_ctrl_pipe2x_old", {448'd0, pipe2x}, 480'd0);
        hold(1'b1, 3); hold(1'b0, 4);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        check("deferred_commit", {479'd0, commit_done}, 480'd1);
        check("deferred_pipe2x", {448'd0, pipe2x}, 480'h55);
        hold(1'b1, 3); hold(1'b0, 4);

        // Reset with a commit pending and screen_end high.
        wr(4'd0, 32'h11);
        hold(1'b1, 1);
        drive(1'b1, 4'd15, 32'd1, 4'd0, 1'b1);
        reset = 1'b1;
        hold(1'b1, 2);
        check("rst_bank", dut_bank, 480'd0);
        check("rst_rd", {448'd0, rd_data}, 480'd0);
        check("rst_underway", {479'd0, game_underway}, 480'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 1);
            check("held_high_no_tick", {479'd0, frame_tick}, 480'd0);
        end
        hold(1'b0, 2);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        check("fresh_edge_tick", {479'd0, frame_tick}, 480'd1);
        check("fresh_edge_no_commit", {479'd0, commit_done}, 480'd0);
        check("fresh_edge_pipe1x", {448'd0, pipe1x}, 480'd0);
        hold(1'b1, 3); hold(1'b0, 4);

        // Status word read.
        do_reset();
        frame(); frame(); frame();
        wr(4'd15, 32'hdead);
        drive(1'b0, 4'd0, 32'd0, 4'd15, 1'b0);
        check("status_read", {448'd0, rd_data}, 480'h80000003);

        // Frame counter wrap after 65535 edges from reset.
        do_reset();
        for (int k = 0; k < 65535; k++) begin
            drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
            drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        end
        check("count_ffff", {464'd0, frame_count}, 480'hffff);
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        check("count_wrap", {464'd0, frame_count}, 480'd0);
        hold(1'b1, 3);
        check("count_once_per_frame", {464'd0, frame_count}, 480'd0);
        hold(1'b0, 4);

        // Randomized traffic against the model.
        se_lvl  = 1'b0;
        se_left = 4;
        for (int c = 0; c < 3000; c++) begin
            if (se_left == 0) begin
                se_lvl  = ~se_lvl;
                se_left = $urandom_range(4, 9);
            end
            se_left--;
            reset = ($urandom_range(0, 499) == 0);
            case ($urandom_range(0, 3))
                0:       wr_data = 32'd0;
                1:       wr_data = $urandom_range(1, 255);
                default: wr_data = $urandom;
            endcase
            drive($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), wr_data,
                  4'($urandom_range(0, 15)), se_lvl);
        end
        reset = 1'b0;
        hold(1'b0, 2);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 480'(exp_q.size()), 480'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
